// File: rtl/sd_reg_update_ctrl_pkg.sv
// Package for the SD register-bank update controller.
// Holds the response-format enum, error codes, FSM states, requester ids,
// the bank write bundle and the CID command indices.
package sd_reg_pkg;

  typedef enum logic [2:0] {
    RESP_NONE    = 3'd0,
    RESP_R1      = 3'd1,
    RESP_R1B     = 3'd2,
    RESP_R2      = 3'd3,
    RESP_R3      = 3'd4,
    RESP_R6      = 3'd5,
    RESP_R7      = 3'd6,
    RESP_ILLEGAL = 3'd7
  } resp_type_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CRC     = 2'd1;
  localparam logic [1:0] ERR_INDEX   = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_ERROR  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SRC_RESP = 2'd0,
    SRC_SCR  = 2'd1,
    SRC_HOST = 2'd2
  } src_e;

  // CMD2 (ALL_SEND_CID) and CMD10 (SEND_CID) return the CID; other R2s carry the CSD
  localparam logic [5:0] CID_CMD_ALL  = 6'd2;
  localparam logic [5:0] CID_CMD_SEND = 6'd10;

  // Bit positions inside the enable vector
  localparam int EN_CID  = 6;
  localparam int EN_CSD  = 5;
  localparam int EN_RCA  = 4;
  localparam int EN_DSR  = 3;
  localparam int EN_OCR  = 2;
  localparam int EN_SCR  = 1;
  localparam int EN_STAT = 0;

  typedef struct packed {
    logic [6:0]   en;
    logic [127:0] cid_d;
    logic [127:0] csd_d;
    logic [63:0]  scr_d;
    logic [63:0]  stat_d;
    logic [31:0]  ocr_d;
    logic [15:0]  rca_d;
    logic [15:0]  dsr_d;
  } bank_wr_t;

  // Formats whose bit [45:40] echoes the command index and are CRC7-protected
  function automatic logic has_index(input resp_type_e t);
    return (t == RESP_R1) || (t == RESP_R1B) || (t == RESP_R6) || (t == RESP_R7);
  endfunction

endpackage

// File: rtl/sd_reg_update_ctrl_if.sv
// Request-side bundle of the register update controller.
// Carries the CMD-line response handshake, the SCR payload handshake and the
// host RCA/DSR write handshake. master = requesters, slave = controller.
interface sd_reg_update_ctrl_if;
  import sd_reg_pkg::*;

  logic         resp_valid;
  logic         resp_ready;
  resp_type_e   resp_type;
  logic [5:0]   resp_cmd;
  logic [135:0] resp_data;
  logic         resp_crc_ok;

  logic         scr_valid;
  logic         scr_ready;
  logic [63:0]  scr_data;

  logic         host_wr_valid;
  logic         host_wr_ready;
  logic         host_wr_sel;
  logic [15:0]  host_wr_data;

  modport master (
    output resp_valid, resp_type, resp_cmd, resp_data, resp_crc_ok,
    output scr_valid, scr_data,
    output host_wr_valid, host_wr_sel, host_wr_data,
    input  resp_ready, scr_ready, host_wr_ready
  );

  modport slave (
    input  resp_valid, resp_type, resp_cmd, resp_data, resp_crc_ok,
    input  scr_valid, scr_data,
    input  host_wr_valid, host_wr_sel, host_wr_data,
    output resp_ready, scr_ready, host_wr_ready
  );

endinterface

// File: rtl/sd_reg_update_ctrl_resp_format.sv
// Combinational formatter: maps a captured transaction to bank data and
// load enables.
// Ports: src (requester), rtype/cmd/data (captured response or payload),
//        host_sel (0 = RCA, 1 = DSR), wr (enable vector plus data).
module sd_resp_format
  import sd_reg_pkg::*;
#(
  parameter logic [5:0] NONE_IDX = 6'h3F
) (
  input  src_e         src,
  input  resp_type_e   rtype,
  input  logic [5:0]   cmd,
  input  logic [127:0] data,
  input  logic         host_sel,
  output bank_wr_t     wr
);

  // Per-format decode of the captured transaction into bank writes
  always_comb begin
    wr = '0;
    case (src)
      SRC_RESP: begin
        case (rtype)
          RESP_NONE: begin
            wr.en[EN_STAT] = 1'b1;
            wr.stat_d      = {26'd0, cmd, 32'd0};
          end
          RESP_R1, RESP_R1B: begin
            wr.en[EN_STAT] = 1'b1;
            wr.stat_d      = {26'd0, cmd, data[39:8]};
          end
          RESP_R2: begin
            // Response bit 0 is the end bit, stored as 1
            if ((cmd == CID_CMD_ALL) || (cmd == CID_CMD_SEND)) begin
              wr.en[EN_CID] = 1'b1;
              wr.cid_d      = {data[127:1], 1'b1};
            end else begin
              wr.en[EN_CSD] = 1'b1;
              wr.csd_d      = {data[127:1], 1'b1};
            end
            wr.en[EN_STAT] = 1'b1;
            wr.stat_d      = {26'd0, NONE_IDX, 32'd0};
          end
          RESP_R3: begin
            wr.en[EN_OCR]  = 1'b1;
            wr.ocr_d       = data[39:8];
            wr.en[EN_STAT] = 1'b1;
            wr.stat_d      = {26'd0, NONE_IDX, 32'd0};
          end
          RESP_R6: begin
            // R6 status bits 23/22/21 map to card status 23/22/19
            wr.en[EN_RCA]  = 1'b1;
            wr.rca_d       = data[39:24];
            wr.en[EN_STAT] = 1'b1;
            wr.stat_d      = {26'd0, cmd, 8'd0, data[23], data[22], 2'd0,
                              data[21], 6'd0, data[20:8]};
          end
          RESP_R7: begin
            wr.en[EN_STAT] = 1'b1;
            wr.stat_d      = {26'd0, cmd, 20'd0, data[19:8]};
          end
          default: begin
            wr = '0;
          end
        endcase
      end
      SRC_SCR: begin
        wr.en[EN_SCR] = 1'b1;
        wr.scr_d      = data[63:0];
      end
      SRC_HOST: begin
        if (host_sel) begin
          wr.en[EN_DSR] = 1'b1;
          wr.dsr_d      = data[15:0];
        end else begin
          wr.en[EN_RCA] = 1'b1;
          wr.rca_d      = data[15:0];
        end
      end
      default: begin
        wr = '0;
      end
    endcase
  end

endmodule

// File: rtl/sd_reg_update_ctrl.sv
// SD register bank update controller.
// Arbitrates CMD responses, SCR payloads and host RCA/DSR writes (fixed
// priority), checks response integrity and issues one-cycle registered load
// enables with data to the CID/CSD/RCA/DSR/OCR/SCR/STATUS bank.
// Ports: clk, reset (async, active-high); req (slave side of the request
//        bundle); *_en / *_d bank writes; busy; err_valid/err_code.
module sd_reg_update_ctrl
  import sd_reg_pkg::*;
#(
  parameter bit         CHECK_CRC = 1'b1,
  parameter logic [5:0] NONE_IDX  = 6'h3F
) (
  input  logic                 clk,
  input  logic                 reset,
  sd_reg_update_ctrl_if.slave  req,
  output logic                 cid_en,
  output logic                 csd_en,
  output logic                 rca_en,
  output logic                 dsr_en,
  output logic                 ocr_en,
  output logic                 scr_en,
  output logic                 stat_en,
  output logic [127:0]         cid_d,
  output logic [127:0]         csd_d,
  output logic [63:0]          scr_d,
  output logic [63:0]          stat_d,
  output logic [31:0]          ocr_d,
  output logic [15:0]          rca_d,
  output logic [15:0]          dsr_d,
  output logic                 busy,
  output logic                 err_valid,
  output logic [1:0]           err_code
);

  state_e       state_r, state_s;
  src_e         grant_s;
  logic         any_req_s;
  logic         take_s;
  logic [1:0]   check_code_s;
  bank_wr_t     wr_s;
  bank_wr_t     out_r;
  logic         busy_r;
  logic         err_valid_r;
  logic [1:0]   err_code_r;

  src_e         cap_src_r;
  resp_type_e   cap_type_r;
  logic [5:0]   cap_cmd_r;
  logic [127:0] cap_data_r;
  logic         cap_crc_ok_r;
  logic         cap_sel_r;

  // Fixed-priority grant: response, then SCR, then host
  always_comb begin
    any_req_s = 1'b0;
    grant_s   = SRC_RESP;
    if (req.resp_valid) begin
      any_req_s = 1'b1;
      grant_s   = SRC_RESP;
    end else if (req.scr_valid) begin
      any_req_s = 1'b1;
      grant_s   = SRC_SCR;
    end else if (req.host_wr_valid) begin
      any_req_s = 1'b1;
      grant_s   = SRC_HOST;
    end else begin
      any_req_s = 1'b0;
      grant_s   = SRC_RESP;
    end
  end

  assign take_s            = (state_r == ST_IDLE) && any_req_s;
  assign req.resp_ready    = take_s && (grant_s == SRC_RESP);
  assign req.scr_ready     = take_s && (grant_s == SRC_SCR);
  assign req.host_wr_ready = take_s && (grant_s == SRC_HOST);

  // Capture register for the granted transaction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_src_r    <= SRC_RESP;
      cap_type_r   <= RESP_NONE;
      cap_cmd_r    <= 6'd0;
      cap_data_r   <= 128'd0;
      cap_crc_ok_r <= 1'b0;
      cap_sel_r    <= 1'b0;
    end else if (take_s) begin
      cap_src_r <= grant_s;
      case (grant_s)
        SRC_RESP: begin
          cap_type_r   <= req.resp_type;
          cap_cmd_r    <= req.resp_cmd;
          cap_data_r   <= req.resp_data[127:0];
          cap_crc_ok_r <= req.resp_crc_ok;
          cap_sel_r    <= 1'b0;
        end
        SRC_SCR: begin
          cap_type_r   <= RESP_NONE;
          cap_cmd_r    <= 6'd0;
          cap_data_r   <= {64'd0, req.scr_data};
          cap_crc_ok_r <= 1'b1;
          cap_sel_r    <= 1'b0;
        end
        default: begin
          cap_type_r   <= RESP_NONE;
          cap_cmd_r    <= 6'd0;
          cap_data_r   <= {112'd0, req.host_wr_data};
          cap_crc_ok_r <= 1'b1;
          cap_sel_r    <= req.host_wr_sel;
        end
      endcase
    end
  end

  // Integrity checks on the captured response, highest priority first
  always_comb begin
    check_code_s = ERR_NONE;
    if (cap_src_r != SRC_RESP) begin
      check_code_s = ERR_NONE;
    end else if (cap_type_r == RESP_ILLEGAL) begin
      check_code_s = ERR_ILLEGAL;
    end else if (has_index(cap_type_r) && (CHECK_CRC == 1'b1) && !cap_crc_ok_r) begin
      check_code_s = ERR_CRC;
    end else if (has_index(cap_type_r) && (cap_data_r[45:40] != cap_cmd_r)) begin
      check_code_s = ERR_INDEX;
    end else begin
      check_code_s = ERR_NONE;
    end
  end

  sd_resp_format #(.NONE_IDX(NONE_IDX)) u_format (
    .src      (cap_src_r),
    .rtype    (cap_type_r),
    .cmd      (cap_cmd_r),
    .data     (cap_data_r),
    .host_sel (cap_sel_r),
    .wr       (wr_s)
  );

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (take_s) begin
          state_s = ST_CHECK;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (check_code_s == ERR_NONE) begin
          state_s = ST_COMMIT;
        end else begin
          state_s = ST_ERROR;
        end
      end
      ST_COMMIT: state_s = ST_IDLE;
      ST_ERROR:  state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered bank writes, busy and error reporting, aligned to the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_r       <= '0;
      busy_r      <= 1'b0;
      err_valid_r <= 1'b0;
      err_code_r  <= ERR_NONE;
    end else begin
      busy_r      <= (state_s != ST_IDLE);
      err_valid_r <= (state_s == ST_ERROR);
      if (state_s == ST_COMMIT) begin
        out_r <= wr_s;
      end else begin
        out_r.en <= 7'd0;
      end
      if (state_s == ST_ERROR) begin
        err_code_r <= check_code_s;
      end else begin
        err_code_r <= err_code_r;
      end
    end
  end

  assign cid_en    = out_r.en[EN_CID];
  assign csd_en    = out_r.en[EN_CSD];
  assign rca_en    = out_r.en[EN_RCA];
  assign dsr_en    = out_r.en[EN_DSR];
  assign ocr_en    = out_r.en[EN_OCR];
  assign scr_en    = out_r.en[EN_SCR];
  assign stat_en   = out_r.en[EN_STAT];
  assign cid_d     = out_r.cid_d;
  assign csd_d     = out_r.csd_d;
  assign scr_d     = out_r.scr_d;
  assign stat_d    = out_r.stat_d;
  assign ocr_d     = out_r.ocr_d;
  assign rca_d     = out_r.rca_d;
  assign dsr_d     = out_r.dsr_d;
  assign busy      = busy_r;
  assign err_valid = err_valid_r;
  assign err_code  = err_code_r;

endmodule

// File: tb/tb_sd_reg_update_ctrl.sv
// Self-checking bench for sd_reg_update_ctrl: directed scenarios plus
// randomized transactions compared against a behavioural model.
module tb_sd_reg_update_ctrl;
  import sd_reg_pkg::*;

  logic         clk;
  logic         reset;
  logic         cid_en, csd_en, rca_en, dsr_en, ocr_en, scr_en, stat_en;
  logic [127:0] cid_d, csd_d;
  logic [63:0]  scr_d, stat_d;
  logic [31:0]  ocr_d;
  logic [15:0]  rca_d, dsr_d;
  logic         busy, err_valid;
  logic [1:0]   err_code;
  logic [6:0]   dut_en;

  int           n_checks;
  int           n_errors;
  logic [1:0]   last_code;

  typedef struct packed {
    logic [6:0]   en;
    logic         err;
    logic [1:0]   code;
    logic [127:0] cid;
    logic [127:0] csd;
    logic [63:0]  scr;
    logic [63:0]  stat;
    logic [31:0]  ocr;
    logic [15:0]  rca;
    logic [15:0]  dsr;
  } exp_t;

  sd_reg_update_ctrl_if bus ();

  sd_reg_update_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req       (bus),
    .cid_en    (cid_en),
    .csd_en    (csd_en),
    .rca_en    (rca_en),
    .dsr_en    (dsr_en),
    .ocr_en    (ocr_en),
    .scr_en    (scr_en),
    .stat_en   (stat_en),
    .cid_d     (cid_d),
    .csd_d     (csd_d),
    .scr_d     (scr_d),
    .stat_d    (stat_d),
    .ocr_d     (ocr_d),
    .rca_d     (rca_d),
    .dsr_d     (dsr_d),
    .busy      (busy),
    .err_valid (err_valid),
    .err_code  (err_code)
  );

  assign dut_en = {cid_en, csd_en, rca_en, dsr_en, ocr_en, scr_en, stat_en};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: src 0 = response, 1 = SCR, 2 = host
  function automatic exp_t model(input int src, input logic [2:0] t, input logic [5:0] cmd,
                                 input logic [135:0] r, input logic crc, input logic sel,
                                 input logic [15:0] hdata, input logic [63:0] sdata);
    exp_t e;
    logic idx_fmt;
    logic [63:0] st_none;
    e = '0;
    st_none = 64'h0000_003F_0000_0000;
    idx_fmt = (t == 3'd1) || (t == 3'd2) || (t == 3'd5) || (t == 3'd6);
    if (src == 1) begin
      e.en = 7'b000_0010; e.scr = sdata;
    end else if (src == 2) begin
      if (sel) begin e.en = 7'b000_1000; e.dsr = hdata; end
      else begin e.en = 7'b001_0000; e.rca = hdata; end
    end else if (t == 3'd7) begin
      e.err = 1'b1; e.code = 2'd3;
    end else if (idx_fmt && !crc) begin
      e.err = 1'b1; e.code = 2'd1;
    end else if (idx_fmt && (r[45:40] != cmd)) begin
      e.err = 1'b1; e.code = 2'd2;
    end else begin
      e.en = 7'b000_0001;
      case (t)
        3'd0: e.stat = 64'(cmd) << 32;
        3'd1, 3'd2: e.stat = (64'(cmd) << 32) + 64'(r[39:8]);
        3'd3: begin
          e.stat = st_none;
          if (cmd == 6'd2 || cmd == 6'd10) begin e.en[6] = 1'b1; e.cid = r[127:0] | 128'd1; end
          else begin e.en[5] = 1'b1; e.csd = r[127:0] | 128'd1; end
        end
        3'd4: begin e.stat = st_none; e.en[2] = 1'b1; e.ocr = r[39:8]; end
        3'd5: begin
          e.en[4] = 1'b1; e.rca = r[39:24];
          e.stat = (64'(cmd) << 32) + (64'(r[23]) << 23) + (64'(r[22]) << 22)
                 + (64'(r[21]) << 19) + 64'(r[20:8]);
        end
        default: e.stat = (64'(cmd) << 32) + 64'(r[19:8]);
      endcase
    end
    return e;
  endfunction

  task automatic run_txn(input string tag, input int src, input logic [2:0] t, input logic [5:0] cmd,
                         input logic [135:0] r, input logic crc, input logic sel,
                         input logic [15:0] hdata, input logic [63:0] sdata);
    exp_t e;
    e = model(src, t, cmd, r, crc, sel, hdata, sdata);
    @(negedge clk);
    bus.resp_type = resp_type_e'(t); bus.resp_cmd = cmd; bus.resp_data = r; bus.resp_crc_ok = crc;
    bus.scr_data = sdata; bus.host_wr_sel = sel; bus.host_wr_data = hdata;
    bus.resp_valid = (src == 0); bus.scr_valid = (src == 1); bus.host_wr_valid = (src == 2);
    #1;
    check_val({tag, "_ready"}, {bus.resp_ready, bus.scr_ready, bus.host_wr_ready},
              {src == 0, src == 1, src == 2});
    @(posedge clk);
    @(negedge clk);
    bus.resp_valid = 1'b0; bus.scr_valid = 1'b0; bus.host_wr_valid = 1'b0;
    check_val({tag, "_chk_state"}, {busy, dut_en, err_valid}, {1'b1, 7'd0, 1'b0});
    @(negedge clk);
    check_val({tag, "_en"}, dut_en, e.en);
    check_val({tag, "_err_valid"}, err_valid, e.err);
    if (e.err) last_code = e.code;
    check_val({tag, "_err_code"}, err_code, last_code);
    if (e.en[6]) check_val({tag, "_cid_d"}, cid_d, e.cid);
    if (e.en[5]) check_val({tag, "_csd_d"}, csd_d, e.csd);
    if (e.en[4]) check_val({tag, "_rca_d"}, rca_d, e.rca);
    if (e.en[3]) check_val({tag, "_dsr_d"}, dsr_d, e.dsr);
    if (e.en[2]) check_val({tag, "_ocr_d"}, ocr_d, e.ocr);
    if (e.en[1]) check_val({tag, "_scr_d"}, scr_d, e.scr);
    if (e.en[0]) check_val({tag, "_stat_d"}, stat_d, e.stat);
    @(negedge clk);
    check_val({tag, "_idle"}, {busy, dut_en, err_valid}, {1'b0, 7'd0, 1'b0});
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ctl"}, {busy, dut_en, err_valid, err_code}, 136'd0);
    check_val({tag, "_data"}, |{cid_d, csd_d, scr_d, stat_d, ocr_d, rca_d, dsr_d}, 136'd0);
  endtask

  initial begin
    logic [135:0] r;
    int hs[3];
    int en_at[3];
    n_checks = 0; n_errors = 0; last_code = 2'd0;
    reset = 1'b1;
    bus.resp_valid = 1'b0; bus.resp_type = RESP_NONE; bus.resp_cmd = 6'd0;
    bus.resp_data = 136'd0; bus.resp_crc_ok = 1'b0;
    bus.scr_valid = 1'b0; bus.scr_data = 64'd0;
    bus.host_wr_valid = 1'b0; bus.host_wr_sel = 1'b0; bus.host_wr_data = 16'd0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("after_reset");

    // R1, cmd 17
    r = 136'd0; r[45:40] = 6'd17; r[39:8] = 32'h0000_0900;
    run_txn("r1", 0, 3'd1, 6'd17, r, 1'b1, 1'b0, 16'd0, 64'd0);
    // R6, cmd 3
    r = 136'd0; r[45:40] = 6'd3; r[39:24] = 16'hB368; r[23:8] = 16'hE500;
    run_txn("r6", 0, 3'd5, 6'd3, r, 1'b1, 1'b0, 16'd0, 64'd0);
    // R2 CSD then CID
    r = 136'd0; r[127:1] = {127{1'b1}};
    run_txn("r2_csd", 0, 3'd3, 6'd9, r, 1'b0, 1'b0, 16'd0, 64'd0);
    run_txn("r2_cid", 0, 3'd3, 6'd2, r, 1'b0, 1'b0, 16'd0, 64'd0);
    // CRC + index error together, then index only
    r = 136'd0; r[45:40] = 6'd5;
    run_txn("err_crc", 0, 3'd1, 6'd17, r, 1'b0, 1'b0, 16'd0, 64'd0);
    run_txn("err_idx", 0, 3'd1, 6'd17, r, 1'b1, 1'b0, 16'd0, 64'd0);
    run_txn("err_ill", 0, 3'd7, 6'd17, r, 1'b1, 1'b0, 16'd0, 64'd0);
    run_txn("r_none", 0, 3'd0, 6'd0, r, 1'b0, 1'b0, 16'd0, 64'd0);

    // All three requesters at once
    hs = '{-1, -1, -1}; en_at = '{-1, -1, -1};
    @(negedge clk);
    r = 136'd0; r[45:40] = 6'd17; r[39:8] = 32'hCAFE_0001;
    bus.resp_type = RESP_R1; bus.resp_cmd = 6'd17; bus.resp_data = r; bus.resp_crc_ok = 1'b1;
    bus.scr_data = 64'h0123_4567_89AB_CDEF; bus.host_wr_sel = 1'b1; bus.host_wr_data = 16'h0404;
    bus.resp_valid = 1'b1; bus.scr_valid = 1'b1; bus.host_wr_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      check_val("one_ready", {bus.resp_ready, bus.scr_ready, bus.host_wr_ready} inside
                {3'b000, 3'b001, 3'b010, 3'b100}, 136'd1);
      if (bus.resp_valid && bus.resp_ready) hs[0] = k;
      if (bus.scr_valid && bus.scr_ready) hs[1] = k;
      if (bus.host_wr_valid && bus.host_wr_ready) hs[2] = k;
      if (stat_en && en_at[0] < 0) en_at[0] = k;
      if (scr_en && en_at[1] < 0) begin
        en_at[1] = k; check_val("arb_scr_d", scr_d, 64'h0123_4567_89AB_CDEF);
      end
      if (dsr_en && en_at[2] < 0) begin
        en_at[2] = k; check_val("arb_dsr_d", dsr_d, 16'h0404);
      end
      @(posedge clk);
      @(negedge clk);
      if (hs[0] == k) bus.resp_valid = 1'b0;
      if (hs[1] == k) bus.scr_valid = 1'b0;
      if (hs[2] == k) bus.host_wr_valid = 1'b0;
    end
    check_val("arb_hs_order", {32'(hs[0]), 32'(hs[1]), 32'(hs[2])}, {32'd0, 32'd3, 32'd6});
    check_val("arb_en_times", {32'(en_at[0]), 32'(en_at[1]), 32'(en_at[2])}, {32'd2, 32'd5, 32'd8});

    // Randomized transactions
    for (int i = 0; i < 60; i++) begin
      int src;
      logic [2:0] t;
      logic [5:0] cmd;
      src = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 2));
      t = 3'($urandom_range(0, 7));
      cmd = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 6'd2 : 6'd10) : 6'($urandom);
      r = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
      if ($urandom_range(0, 3) != 0) r[45:40] = cmd;
      run_txn("rand", src, t, cmd, r, $urandom_range(0, 4) != 0, 1'($urandom),
              16'($urandom), {$urandom, $urandom});
    end

    // Reset during CHECK of an R3
    @(negedge clk);
    r = 136'd0; r[39:8] = 32'h80FF_8000;
    bus.resp_type = RESP_R3; bus.resp_cmd = 6'd41; bus.resp_data = r; bus.resp_crc_ok = 1'b0;
    bus.resp_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_valid = 1'b0;
    check_val("rst_mid_busy_before", busy, 1'b1);
    reset = 1'b1;
    #1;
    check_all_zero("rst_mid_async");
    repeat (2) begin
      @(negedge clk);
      check_val("rst_mid_no_ocr", ocr_en, 1'b0);
    end
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid_released");
    bus.resp_valid = 1'b1;
    #1;
    check_val("rst_mid_ready", bus.resp_ready, 1'b1);
    bus.resp_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_val("rst_mid_quiet", {busy, dut_en}, 8'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
